sha256_core: RTL

SHA256_CORE -- requirements
Module: sha256_core

---
 rtl/sha256_core_if.sv | 24 ++
 rtl/sha256_core.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_core_if.sv
// Block-in / digest-out handshake bundle for sha256_core.
// Signal suffixes are relative to the core (slave side).
interface sha256_core_if;
   logic [511:0] blk_i;
   logic         blk_vld_i;
   logic         blk_rdy_o;
   logic         first_i;
   logic         last_i;
   logic         mode_i;
   logic [255:0] hash_o;
   logic         hash_vld_o;
   logic         hash_rdy_i;
   logic         busy_o;

   modport master (
      output blk_i, blk_vld_i, first_i, last_i, mode_i, hash_rdy_i,
      input  blk_rdy_o, hash_o, hash_vld_o, busy_o
   );

   modport slave (
      input  blk_i, blk_vld_i, first_i, last_i, mode_i, hash_rdy_i,
      output blk_rdy_o, hash_o, hash_vld_o, busy_o
   );
endinterface

// File: rtl/sha256_core.sv
// SHA-256 / SHA-224 compression core: one 512-bit block per 64/UNROLL+2 cycles,
// rolling 16-word schedule, digest presented in OUT with optional hold handshake.
package sha256_pkg;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction
endpackage

// One compression round plus one schedule step; w_i[0] is W[t].
module sha256_round
   import sha256_pkg::*;
(
   input  logic [7:0][31:0]  wv_i,
   input  logic [15:0][31:0] w_i,
   input  logic [31:0]       k_i,
   output logic [7:0][31:0]  wv_o,
   output logic [15:0][31:0] w_o
);
   logic [31:0] t1, t2, ch, maj, w_new;

   always_comb begin
      ch    = (wv_i[4] & wv_i[5]) ^ (~wv_i[4] & wv_i[6]);
      maj   = (wv_i[0] & wv_i[1]) ^ (wv_i[0] & wv_i[2]) ^ (wv_i[1] & wv_i[2]);
      t1    = wv_i[7] + bsig1(wv_i[4]) + ch + k_i + w_i[0];
      t2    = bsig0(wv_i[0]) + maj;
      // W[t+16] from the window; computed past round 63 too, where it is simply unused
      w_new = ssig1(w_i[14]) + w_i[9] + ssig0(w_i[1]) + w_i[0];

      wv_o[0] = t1 + t2;
      wv_o[1] = wv_i[0];
      wv_o[2] = wv_i[1];
      wv_o[3] = wv_i[2];
      wv_o[4] = wv_i[3] + t1;
      wv_o[5] = wv_i[4];
      wv_o[6] = wv_i[5];
      wv_o[7] = wv_i[6];

      for (int i = 0; i < 15; i++) w_o[i] = w_i[i+1];
      w_o[15] = w_new;
   end
endmodule

module sha256_core
   import sha256_pkg::*;
#(
   parameter int UNROLL   = 1,
   parameter int OUT_HOLD = 1
) (
   input  logic         clk,
   input  logic         rstn_i,
   sha256_core_if.slave bus
);
   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
      $error("sha256_core: UNROLL must be 1, 2 or 4");
   end

   localparam logic [5:0] LAST_RND = 6'(64 - UNROLL);

   typedef enum logic [1:0] {IDLE, ROUNDS, UPD, OUT} state_e;

   state_e            state_q, state_d;
   logic              init_q, init_d;
   logic [7:0][31:0]  h_q, h_d;
   logic [7:0][31:0]  wv_q, wv_d;
   logic [15:0][31:0] w_q, w_d;
   logic [5:0]        rnd_q, rnd_d;
   logic              last_q, last_d;
   logic              mode_q, mode_d;

   logic              blk_rdy, busy, hash_vld, accept;
   logic [255:0]      hash;

   logic [UNROLL:0][7:0][31:0]  wv_c;
   logic [UNROLL:0][15:0][31:0] w_c;

   assign accept = bus.blk_vld_i & blk_rdy;

   assign wv_c[0] = wv_q;
   assign w_c[0]  = w_q;

   for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
      sha256_round u_rnd (
         .wv_i (wv_c[g]),
         .w_i  (w_c[g]),
         .k_i  (K[rnd_q + 6'(g)]),
         .wv_o (wv_c[g+1]),
         .w_o  (w_c[g+1])
      );
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ROUNDS;
         ROUNDS:  if (rnd_q == LAST_RND) state_d = UPD;
         UPD:     state_d = last_q ? OUT : IDLE;
         OUT:     if (OUT_HOLD == 0 || bus.hash_rdy_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      blk_rdy  = 1'b0;
      busy     = 1'b1;
      hash_vld = 1'b0;
      hash     = '0;
      case (state_q)
         IDLE: begin
            // held low until the first clock after reset release
            blk_rdy = init_q;
            busy    = 1'b0;
         end
         OUT: begin
            hash_vld = 1'b1;
            hash     = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6],
                        mode_q ? 32'h0 : h_q[7]};
         end
         default: ;
      endcase
   end

   assign bus.blk_rdy_o  = blk_rdy;
   assign bus.busy_o     = busy;
   assign bus.hash_vld_o = hash_vld;
   assign bus.hash_o     = hash;

   always_comb begin
      init_d = 1'b1;
      h_d    = h_q;
      wv_d   = wv_q;
      w_d    = w_q;
      rnd_d  = rnd_q;
      last_d = last_q;
      mode_d = mode_q;
      case (state_q)
         IDLE: if (accept) begin
            if (bus.first_i) begin
               mode_d = bus.mode_i;
               for (int i = 0; i < 8; i++) h_d[i] = bus.mode_i ? IV224[i] : IV256[i];
               wv_d = h_d;
            end else begin
               wv_d = h_q;
            end
            for (int i = 0; i < 16; i++) w_d[i] = bus.blk_i[511-32*i -: 32];
            last_d = bus.last_i;
            rnd_d  = '0;
         end
         ROUNDS: begin
            wv_d  = wv_c[UNROLL];
            w_d   = w_c[UNROLL];
            rnd_d = rnd_q + 6'(UNROLL);
         end
         UPD: for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         init_q <= 1'b0;
         for (int i = 0; i < 8; i++) h_q[i] <= IV256[i];
         wv_q   <= '0;
         w_q    <= '0;
         rnd_q  <= '0;
         last_q <= 1'b0;
         mode_q <= 1'b0;
      end else begin
         init_q <= init_d;
         h_q    <= h_d;
         wv_q   <= wv_d;
         w_q    <= w_d;
         rnd_q  <= rnd_d;
         last_q <= last_d;
         mode_q <= mode_d;
      end
   end
endmodule
